// File: rtl/signed_acc_pkg.sv
// Shared types, default widths and saturation limits for the signed product accumulator.
// Saturation limits are only referenced when ACC_SATURATE_EN is defined.
package signed_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned PROD_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 16;
    localparam int unsigned CNT_W_DEF  = 8;

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational sign-extend, add and overflow detect for the accumulator.
// Clamps to the signed limits on overflow when ACC_SATURATE_EN is defined, otherwise wraps.
module acc_sat_add
    import signed_acc_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [PROD_W-1:0] i_product,
    output logic signed [ACC_W-1:0]  o_sum,
    output logic                     o_ovf
);

    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_raw;

    assign w_ext = ACC_W'(i_product);
    assign w_raw = i_acc + w_ext;

    // Overflow only when both operands agree in sign and the result does not.
    assign o_ovf = (i_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_raw[ACC_W-1] != i_acc[ACC_W-1]);

`ifdef ACC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    always_comb begin
        o_sum = w_raw;
        if (o_ovf) begin
            o_sum = i_acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign o_sum = w_raw;
`endif

endmodule

// File: rtl/signed_product_accumulator.sv
// Frame accumulator for signed multiplier products with valid/ready on both sides.
// Optional saturation of the accumulator is enabled by defining ACC_SATURATE_EN.
module signed_product_accumulator
    import signed_acc_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_count;
    logic                    r_ovf;
    logic [ACC_W-1:0]        r_out_sum;
    logic [CNT_W-1:0]        r_out_count;
    logic                    r_out_ovf;

    logic                    w_xfer;
    logic                    w_start;
    logic signed [ACC_W-1:0] w_add_base;
    logic signed [ACC_W-1:0] w_add_sum;
    logic                    w_add_ovf;
    logic [CNT_W-1:0]        w_count_nxt;
    logic                    w_cnt_sat;
    logic                    w_ovf_nxt;

    // Any beat accepted outside ACCUM opens a new frame, so the adder starts from zero.
    assign w_start    = (r_state != ACCUM);
    assign w_add_base = w_start ? '0 : r_acc;

    acc_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .i_acc     (w_add_base),
        .i_product ($signed(in_product)),
        .o_sum     (w_add_sum),
        .o_ovf     (w_add_ovf)
    );

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE, ACCUM: in_ready = 1'b1;
                DONE:        in_ready = out_ready;
                default:     in_ready = 1'b0;
            endcase
        end
    end

    assign w_xfer = in_valid && in_ready;

    always_comb begin
        w_count_nxt = CNT_ONE;
        w_cnt_sat   = 1'b0;
        if (!w_start) begin
            if (r_count == CNT_MAX) begin
                w_count_nxt = r_count;
                w_cnt_sat   = 1'b1;
            end else begin
                w_count_nxt = r_count + CNT_ONE;
            end
        end
        w_ovf_nxt = (!w_start && r_ovf) || w_add_ovf || w_cnt_sat;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = in_last ? DONE : ACCUM;
        end else if (r_state == DONE && out_ready) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_xfer) begin
            r_acc   <= w_add_sum;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            if (in_last) begin
                r_out_sum   <= w_add_sum;
                r_out_count <= w_count_nxt;
                r_out_ovf   <= w_ovf_nxt;
            end
        end
    end

    assign out_valid = (r_state == DONE);
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_signed_product_accumulator.sv
// Self-checking bench: directed frames, width-override instances and randomized traffic
// checked every cycle against a frame-level behavioural model.
module tb_signed_product_accumulator;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_product;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_sum;
    logic [7:0]         out_count;
    logic               out_ovf;

    logic               p_valid;
    logic [7:0]         p_prod;
    logic               p_last;
    logic               p_out_ready;
    logic               a_in_ready, a_out_valid, a_out_ovf;
    logic signed [7:0]  a_out_sum;
    logic [7:0]         a_out_count;
    logic               c_in_ready, c_out_valid, c_out_ovf;
    logic signed [15:0] c_out_sum;
    logic [1:0]         c_out_count;

    int n_cmp = 0;
    int n_bad = 0;

    signed_product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    signed_product_accumulator #(.PROD_W(8), .ACC_W(8), .CNT_W(8)) u_acc8 (
        .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(a_in_ready),
        .in_product(p_prod), .in_last(p_last), .out_valid(a_out_valid),
        .out_ready(p_out_ready), .out_sum(a_out_sum), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    signed_product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(2)) u_cnt2 (
        .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(c_in_ready),
        .in_product(p_prod), .in_last(p_last), .out_valid(c_out_valid),
        .out_ready(p_out_ready), .out_sum(c_out_sum), .out_count(c_out_count), .out_ovf(c_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: exact integer sum, then range check per beat.
    bit     m_in_frame  = 1'b0;
    bit     m_res_valid = 1'b0;
    longint m_acc       = 0;
    int     m_cnt       = 0;
    bit     m_ovf       = 1'b0;
    longint e_sum       = 0;
    int     e_cnt       = 0;
    bit     e_ovf       = 1'b0;

    always @(posedge clk) begin
        bit ready;
        logic signed [15:0] wrapped;
        ready = !m_res_valid || out_ready;
        if (rst) begin
            m_in_frame  = 1'b0;
            m_res_valid = 1'b0;
        end else begin
            if (m_res_valid && out_ready) m_res_valid = 1'b0;
            if (in_valid && ready) begin
                if (!m_in_frame) begin
                    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_in_frame = 1'b1;
                end
                m_acc = m_acc + longint'($signed(in_product));
                if (m_acc > 32767 || m_acc < -32768) begin
                    m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
                    m_acc = (m_acc > 0) ? 32767 : -32768;
`else
                    wrapped = m_acc[15:0];
                    m_acc = wrapped;
`endif
                end
                if (m_cnt == 255) m_ovf = 1'b1;
                else m_cnt = m_cnt + 1;
                if (in_last) begin
                    e_sum = m_acc; e_cnt = m_cnt; e_ovf = m_ovf;
                    m_res_valid = 1'b1;
                    m_in_frame  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_in_ready", in_ready, (!rst && (!m_res_valid || out_ready)) ? 1 : 0);
        chk("model_out_valid", out_valid, m_res_valid);
        if (m_res_valid) begin
            chk("model_out_sum", out_sum, e_sum);
            chk("model_out_count", out_count, e_cnt);
            chk("model_out_ovf", out_ovf, e_ovf);
        end
    end

    // Called aligned to posedge+#1; returns aligned to posedge+#1 after the transfer edge.
    task automatic beat(input logic signed [7:0] p, input bit last);
        bit taken;
        taken = 1'b0;
        in_valid = 1'b1; in_product = p; in_last = last;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!taken) chk("beat_timeout", 0, 1);
    endtask

    task automatic pbeat(input logic signed [7:0] p, input bit last);
        p_valid = 1'b1; p_prod = p; p_last = last;
        @(posedge clk); #1;
        p_valid = 1'b0; p_last = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
        p_valid = 1'b0; p_prod = '0; p_last = 1'b0; p_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Multiplier products 0, -18, 18, 7
        beat(0, 0); beat(-18, 0); beat(18, 0); beat(7, 1);
        @(negedge clk);
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_sum", out_sum, 7);
        chk("t1_count", out_count, 4);
        chk("t1_ovf", out_ovf, 0);
        @(posedge clk); #1;

        // Backpressure on a single-beat frame
        out_ready = 1'b0;
        beat(-56, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_sum", out_sum, -56);
            chk("t2_hold_count", out_count, 1);
            chk("t2_hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_retired", out_valid, 0);
        @(posedge clk); #1;

        // Retire and start a new frame on the same edge
        out_ready = 1'b0;
        beat(3, 1);
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_product = 8'hF8; in_last = 1'b0;
        @(negedge clk);
        chk("t3_done_in_ready", in_ready, 1);
        chk("t3_old_sum", out_sum, 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_out_valid", out_valid, 0);
        chk("t3_accum_ready", in_ready, 1);
        @(posedge clk); #1;
        beat(2, 1);
        @(negedge clk);
        chk("t3_sum", out_sum, -6);
        chk("t3_count", out_count, 2);
        @(posedge clk); #1;

        // Long frame: accumulator overflow and counter saturation
        for (int i = 0; i < 300; i++) beat(127, (i == 299));
        @(negedge clk);
`ifdef ACC_SATURATE_EN
        chk("t4_sum", out_sum, 32767);
`else
        chk("t4_sum", out_sum, -27436);
`endif
        chk("t4_count", out_count, 255);
        chk("t4_ovf", out_ovf, 1);
        @(posedge clk); #1;

        // Width-override instances
        pbeat(64, 0); pbeat(64, 1);
        @(negedge clk);
        chk("acc8_valid", a_out_valid, 1);
`ifdef ACC_SATURATE_EN
        chk("acc8_sum", a_out_sum, 127);
`else
        chk("acc8_sum", a_out_sum, -128);
`endif
        chk("acc8_ovf", a_out_ovf, 1);
        chk("cnt2_sum_a", c_out_sum, 128);
        chk("cnt2_ovf_a", c_out_ovf, 0);
        @(posedge clk); #1;
        pbeat(1, 0); pbeat(1, 0); pbeat(1, 0); pbeat(1, 1);
        @(negedge clk);
        chk("cnt2_valid", c_out_valid, 1);
        chk("cnt2_count", c_out_count, 3);
        chk("cnt2_ovf", c_out_ovf, 1);
        chk("cnt2_sum", c_out_sum, 4);
        chk("acc8_count_b", a_out_count, 4);
        chk("acc8_ovf_b", a_out_ovf, 0);
        chk("param_in_ready", {a_in_ready, c_in_ready}, 3);
        @(posedge clk); #1;

        // Reset in the middle of a frame
        beat(18, 0); beat(18, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        beat(5, 1);
        @(negedge clk);
        chk("t6_sum", out_sum, 5);
        chk("t6_count", out_count, 1);
        chk("t6_ovf", out_ovf, 0);
        @(posedge clk); #1;

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            in_product = 8'($urandom);
            in_last    = ($urandom_range(0, 5) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_product_accumulator.md
Name: signed_product_accumulator

Overview:
- Sequential stage directly downstream of array_signed_multiplier_4.
- Consumes its 8-bit signed products one beat at a time over a valid/ready handshake and accumulates them into a frame sum (dot-product / MAC tail).
- Delivers the registered sum, beat count and overflow flag on an output valid/ready handshake.
- Frame boundaries are marked by in_last.

Parameters:
- PROD_W, 8, width of the signed product input; matches the 4x4 multiplier output.
- ACC_W, 16, width of the signed accumulator and out_sum; must be >= PROD_W.
- CNT_W, 8, width of the beat counter out_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_product  input  PROD_W  signed product from the multiplier.
- in_last  input  1  final beat of the frame; qualified by a transfer.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  signed frame sum.
- out_count  output  CNT_W  number of beats in the frame.
- out_ovf  output  1  sticky overflow for the frame, from the accumulator or the counter.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising clk edge.
- Reset values: state=IDLE, acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- in_ready is combinational from state. It is 0 while rst is high.
- Transfer rule: a beat is taken when in_valid && in_ready. The result is taken when out_valid && out_ready.
- IDLE state:
  - in_ready=1.
  - A transfer loads acc=sext(in_product) and count=1.
  - Next state: DONE if in_last, else ACCUM.
- ACCUM state:
  - in_ready=1.
  - A transfer does acc+=sext(in_product) and count+=1.
  - in_last moves to DONE.
  - No transfer: hold all state.
- Entering DONE:
  - The final sum (including the last beat) is registered into out_sum, out_count and out_ovf.
  - out_valid=1 on the cycle after the last-beat transfer. Latency is exactly 1 clk.
- DONE state:
  - out_* remain stable until the result is taken.
  - in_ready = out_ready.
- DONE with out_ready=1 and no transfer: go to IDLE; out_valid=0 next cycle.
- DONE with out_ready=1 and a simultaneous beat transfer:
  - The result is retired.
  - The beat starts a new frame (acc=sext(in_product), count=1, ovf=0).
  - Next state is ACCUM, or DONE again if in_last; in that case out_valid stays 1 with the new values.
- DONE with out_ready=0: in_ready=0 and everything holds (backpressure).
- Arithmetic:
  - Two's complement; sign-extend PROD_W to ACC_W.
  - Overflow is detected when both operands have the same sign and the result sign differs.
  - On overflow, ovf is set and stays set for the rest of the frame.
  - Without saturation, the accumulator wraps.
- Counter: count saturates at 2^CNT_W-1 and sets ovf; it never wraps.
- ovf clears only at frame start or on reset.
- in_product and in_last are ignored when no transfer occurs.
- Reset mid-frame: the partial sum is discarded and all state returns to reset values on the next edge.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) according to the operand sign, and ovf is set. The clamp value is used for subsequent beats.
- Undefined: acc wraps modulo 2^ACC_W and ovf is still set.

Decomposition:
- Package signed_acc_pkg holds:
  - state enum {IDLE, ACCUM, DONE}
  - default width constants PROD_W_DEF=8, ACC_W_DEF=16, CNT_W_DEF=8
  - saturation limit helper functions.
- One sub-module, acc_sat_add: combinational sign-extend/add/overflow-detect, with an optional clamp under ACC_SATURATE_EN.
- The FSM and registers stay in the top module.

Test Plan:
- Products from the multiplier pairs (1,0)->0, (-6,3)->-18, (-3,-6)->18, then 7 with last. Expect out_sum=7, out_count=4, out_ovf=0, out_valid high exactly 1 cycle after the last transfer.
- Single beat -56 with last, and out_ready held 0 for 5 cycles. Expect out_sum=-56 and count=1, stable all 5 cycles, in_ready=0; the result is retired on the first out_ready=1 cycle.
- In DONE with out_ready=1, in_valid=1, in_product=-8, in_last=0. Expect the old result retired, the new frame started with acc=-8, count=1, state ACCUM.
- ACC_W=8 override, beats 64 then 64 with last:
  - without macro: out_sum=-128, out_ovf=1.
  - with ACC_SATURATE_EN: out_sum=127, out_ovf=1.
- CNT_W=2, 4 beats of 1 with last on beat 4. Expect out_count=3, out_ovf=1, out_sum=4.
- Two beats of 18, then rst=1 for 1 cycle, then beat 5 with last. Expect out_valid=0 during reset, in_ready=0 during reset, final out_sum=5, out_count=1.
